// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: one AXI read channel pair (AR request plus R response) between a master and a slave.
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int ID_WIDTH        = 8,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_WIDTH      = 8
);
  logic                       ar_valid;
  logic                       ar_ready;
  logic [ADDR_WIDTH-1:0]      ar_addr;
  logic [BURST_LEN_WIDTH-1:0] ar_len;
  logic [ID_WIDTH-1:0]        ar_id;
  logic                       r_valid;
  logic                       r_ready;
  logic [ID_WIDTH-1:0]        r_id;
  logic [DATA_WIDTH-1:0]      r_data;
  logic                       r_last;
  modport master (
    output ar_valid, ar_addr, ar_len, ar_id, r_ready,
    input  ar_ready, r_valid, r_id, r_data, r_last
  );
  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_id, r_ready,
    output ar_ready, r_valid, r_id, r_data, r_last
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbitration of two AXI read masters onto one port through a
// one-entry AR slot, with source-tagged IDs, R routing by tag and per-source outstanding limits.
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int ID_WIDTH        = 8,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int OUTST_WIDTH     = 3
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_arbiter_if.slave   s0,
  axi_rd_arbiter_if.slave   s1,
  axi_rd_arbiter_if.master  m,
  output logic              err_unexpected_r
);
  typedef enum logic {EMPTY, FULL} state_e;
  typedef logic [OUTST_WIDTH-1:0] cnt_t;
  state_e                     state_q, state_d;
  logic                       ptr_q, ptr_d;
  cnt_t                       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [ID_WIDTH:0]          id_q, id_d;
  logic                       err_q, err_d;
  logic                       elig0, elig1, gnt0, gnt1, hs0, hs1;
  logic                       src, r_last_hs, dec0, dec1;
  logic [DATA_WIDTH-1:0]      r_data;
  function automatic cnt_t cnt_next(input cnt_t c, input logic inc, input logic dec);
    return (inc == dec) ? c : inc ? c + 1'b1 : c - 1'b1;
  endfunction
  always_comb begin
    elig0 = s0.ar_valid && (cnt0_q != '1);
    elig1 = s1.ar_valid && (cnt1_q != '1);
    gnt0  = elig0 && (!elig1 || !ptr_q);
    gnt1  = elig1 && (!elig0 || ptr_q);
    hs0   = (state_q == EMPTY) && gnt0;
    hs1   = (state_q == EMPTY) && gnt1;
    src   = m.r_id[ID_WIDTH];
    r_last_hs = m.r_valid && m.r_ready && m.r_last;
    // A last beat for a source with nothing outstanding is flagged, never decremented
    dec0  = r_last_hs && !src && (cnt0_q != '0);
    dec1  = r_last_hs && src && (cnt1_q != '0);
    state_d = (state_q == EMPTY) ? ((hs0 || hs1) ? FULL : EMPTY) : (m.ar_ready ? EMPTY : FULL);
    ptr_d   = hs0 ? 1'b1 : hs1 ? 1'b0 : ptr_q;
    addr_d  = hs0 ? s0.ar_addr : hs1 ? s1.ar_addr : addr_q;
    len_d   = hs0 ? s0.ar_len : hs1 ? s1.ar_len : len_q;
    id_d    = hs0 ? {1'b0, s0.ar_id} : hs1 ? {1'b1, s1.ar_id} : id_q;
    cnt0_d  = cnt_next(cnt0_q, hs0, dec0);
    cnt1_d  = cnt_next(cnt1_q, hs1, dec1);
    err_d   = err_q || (m.r_valid && (src ? (cnt1_q == '0) : (cnt0_q == '0)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
    end
  end
  assign s0.ar_ready = hs0;
  assign s1.ar_ready = hs1;
  assign m.ar_valid  = (state_q == FULL);
  assign m.ar_addr   = addr_q;
  assign m.ar_len    = len_q;
  assign m.ar_id     = id_q;
  assign err_unexpected_r = err_q;
  assign r_data      = m.r_data;
  assign m.r_ready   = src ? s1.r_ready : s0.r_ready;
  assign s0.r_valid  = m.r_valid && !src;
  assign s1.r_valid  = m.r_valid && src;
  assign s0.r_id     = m.r_id[ID_WIDTH-1:0];
  assign s1.r_id     = m.r_id[ID_WIDTH-1:0];
  assign s0.r_data   = r_data;
  assign s1.r_data   = r_data;
  assign s0.r_last   = m.r_last;
  assign s1.r_last   = m.r_last;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of arbitration, throttling, backpressure, R routing and error flag.
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   n_cmp = 0;
  int   n_bad = 0;
  axi_rd_arbiter_if #(.ID_WIDTH(8)) s0_if ();
  axi_rd_arbiter_if #(.ID_WIDTH(8)) s1_if ();
  axi_rd_arbiter_if #(.ID_WIDTH(9)) m_if ();
  axi_rd_arbiter dut (
    .clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if), .err_unexpected_r(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    s0_if.ar_valid = 0; s0_if.ar_addr = '0; s0_if.ar_len = '0; s0_if.ar_id = '0; s0_if.r_ready = 0;
    s1_if.ar_valid = 0; s1_if.ar_addr = '0; s1_if.ar_len = '0; s1_if.ar_id = '0; s1_if.r_ready = 0;
    m_if.ar_ready = 1; m_if.r_valid = 0; m_if.r_id = '0; m_if.r_data = '0; m_if.r_last = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    #1;
  endtask
  initial begin
    int beats;
    idle_inputs();
    tick();
    tick();
    check("rst_ar_valid", m_if.ar_valid, 0);
    check("rst_payload", {m_if.ar_addr, m_if.ar_len, m_if.ar_id}, 0);
    check("rst_err", err, 0);
    check("rst_cnts", {dut.cnt0_q, dut.cnt1_q}, 0);
    s0_if.ar_valid = 1;
    #1 check("rst_s0_ready_comb", s0_if.ar_ready, 1);
    do_reset();
    // single source request and one R beat
    m_if.ar_ready = 0;
    s0_if.ar_valid = 1; s0_if.ar_addr = 16'h5940; s0_if.ar_len = 0; s0_if.ar_id = 8'h05;
    #1 check("single_ready", {s0_if.ar_ready, s1_if.ar_ready}, 2'b10);
    tick();
    s0_if.ar_valid = 0;
    check("single_ar", {m_if.ar_valid, m_if.ar_addr, m_if.ar_len, m_if.ar_id}, {1'b1, 16'h5940, 8'h00, 9'h005});
    m_if.ar_ready = 1;
    tick();
    check("single_ar_done", m_if.ar_valid, 0);
    m_if.r_valid = 1; m_if.r_id = 9'h005; m_if.r_data = 8'hA5; m_if.r_last = 1; s0_if.r_ready = 1;
    #1 check("single_r", {s0_if.r_valid, s0_if.r_id, s0_if.r_data, s1_if.r_valid, m_if.r_ready},
                         {1'b1, 8'h05, 8'hA5, 1'b0, 1'b1});
    tick();
    m_if.r_valid = 0;
    check("single_cnt0", dut.cnt0_q, 0);
    // both sources requesting every cycle alternate
    do_reset();
    s0_if.ar_valid = 1; s0_if.ar_id = 8'h11;
    s1_if.ar_valid = 1; s1_if.ar_id = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_ready%0d", k), {s0_if.ar_ready, s1_if.ar_ready}, (k % 2) ? 2'b01 : 2'b10);
      tick();
      check($sformatf("rr_id%0d", k), m_if.ar_id, (k % 2) ? 9'h122 : 9'h011);
      tick();
    end
    // throttle: seven outstanding s0 bursts block the eighth
    do_reset();
    s0_if.ar_valid = 1; s0_if.ar_id = 8'h01;
    for (int i = 0; i < 7; i++) begin
      #1 check($sformatf("thr_grant%0d", i), s0_if.ar_ready, 1);
      tick();
      tick();
    end
    #1 check("thr_blocked", s0_if.ar_ready, 0);
    s1_if.ar_valid = 1; s1_if.ar_id = 8'h02;
    #1 check("thr_s1_ok", s1_if.ar_ready, 1);
    tick();
    s1_if.ar_valid = 0;
    tick();
    check("thr_still_blocked", s0_if.ar_ready, 0);
    m_if.r_valid = 1; m_if.r_id = 9'h001; m_if.r_last = 1; s0_if.r_ready = 1;
    tick();
    m_if.r_valid = 0;
    #1 check("thr_released", s0_if.ar_ready, 1);
    tick();
    tick();
    check("thr_cnt0", dut.cnt0_q, 7);
    check("thr_reblocked", s0_if.ar_ready, 0);
    // backpressure on the downstream AR channel
    do_reset();
    m_if.ar_ready = 0;
    s0_if.ar_valid = 1; s0_if.ar_addr = 16'h1234; s0_if.ar_len = 8'h07; s0_if.ar_id = 8'h33;
    s1_if.ar_valid = 1; s1_if.ar_addr = 16'hBEEF; s1_if.ar_len = 8'h02; s1_if.ar_id = 8'h44;
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i),
            {m_if.ar_valid, m_if.ar_addr, m_if.ar_len, m_if.ar_id, s0_if.ar_ready, s1_if.ar_ready},
            {1'b1, 16'h1234, 8'h07, 9'h033, 1'b0, 1'b0});
      tick();
    end
    m_if.ar_ready = 1;
    tick();
    check("bp_next_grant", {s0_if.ar_ready, s1_if.ar_ready}, 2'b01);
    tick();
    check("bp_next_ar", {m_if.ar_valid, m_if.ar_addr, m_if.ar_len, m_if.ar_id}, {1'b1, 16'hBEEF, 8'h02, 9'h144});
    s0_if.ar_valid = 0; s1_if.ar_valid = 0;
    tick();
    // R burst to s1 under toggling ready
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      s1_if.r_ready = c[0];
      m_if.r_valid = 1; m_if.r_id = 9'h105; m_if.r_data = 8'h50 + 8'(beats); m_if.r_last = (beats == 3);
      #1 check($sformatf("rt_beat%0d", c),
               {s1_if.r_valid, s0_if.r_valid, m_if.r_ready, s1_if.r_id, s1_if.r_data, s1_if.r_last},
               {1'b1, 1'b0, c[0], 8'h05, 8'h50 + 8'(beats), beats == 3});
      check($sformatf("rt_cnt1_%0d", c), dut.cnt1_q, 1);
      tick();
      if (c[0]) beats++;
    end
    m_if.r_valid = 0;
    check("rt_beats", beats, 4);
    check("rt_cnts", {dut.cnt0_q, dut.cnt1_q}, {3'd1, 3'd0});
    check("rt_no_err", err, 0);
    // unexpected R beat sets the sticky error
    do_reset();
    m_if.r_valid = 1; m_if.r_id = 9'h003; m_if.r_last = 1; s0_if.r_ready = 1;
    #1 check("err_routed", {s0_if.r_valid, err}, 2'b10);
    tick();
    m_if.r_valid = 0;
    check("err_set", err, 1);
    check("err_no_underflow", dut.cnt0_q, 0);
    tick();
    tick();
    tick();
    check("err_sticky", err, 1);
    rst = 1;
    #1 check("err_cleared", err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
